// File: rtl/i2s_encoder.sv
// rtl/i2s_encoder.sv - I2S transmitter with single-entry holding buffer
module i2s_encoder #(
  parameter int DATAWIDTH = 24,
  parameter int SLOT      = 32
) (
  input  logic                 clk_mic,
  input  logic                 rst_mic_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] L_IN,
  input  logic [DATAWIDTH-1:0] R_IN,
  output logic                 in_ready,
  output logic                 WS,
  output logic                 DATA,
  output logic                 frame_start,
  output logic                 underrun
);

  localparam int             CW     = $clog2(2 * SLOT);
  localparam logic [CW-1:0]  LAST   = CW'(2 * SLOT - 1);
  localparam logic [CW-1:0]  SLOT_C = CW'(SLOT);
  localparam logic [CW-1:0]  DW_C   = CW'(DATAWIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   load;
  logic                   full;
  logic                   accept;
  logic                   in_left, in_right;
  logic [DATAWIDTH-1:0]   buf_l, buf_r;
  logic [DATAWIDTH-1:0]   sh_l, sh_r;

  assign in_ready = ~full;
  assign accept   = in_valid & ~full;

  always_ff @(posedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // RUN and DRAIN share the counter; en at the last bit decides load vs. stop
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = LAST;
        if (en) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          load      = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (cnt == LAST) begin
          if (en) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = LAST;
          end
        end else begin
          cnt_nxt   = cnt + CW'(1);
          state_nxt = en ? RUN : DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = LAST;
      end
    endcase
  end

  always_comb begin
    in_left  = (cnt_nxt != '0) && (cnt_nxt <= DW_C);
    in_right = (cnt_nxt > SLOT_C) && (cnt_nxt <= SLOT_C + DW_C);
  end

  always_ff @(posedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      cnt         <= LAST;
      full        <= 1'b0;
      buf_l       <= '0;
      buf_r       <= '0;
      sh_l        <= '0;
      sh_r        <= '0;
      WS          <= 1'b1;
      DATA        <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      WS          <= (cnt_nxt >= SLOT_C);
      frame_start <= load;
      underrun    <= load & ~full;
      if (accept) begin
        buf_l <= L_IN;
        buf_r <= R_IN;
      end
      // a pair offered on an empty-buffer load edge waits for the next frame
      full <= load ? accept : (full | accept);
      if (load) begin
        sh_l <= full ? buf_l : '0;
        sh_r <= full ? buf_r : '0;
        DATA <= 1'b0;
      end else if (in_left) begin
        DATA <= sh_l[DATAWIDTH-1];
        sh_l <= sh_l << 1;
      end else if (in_right) begin
        DATA <= sh_r[DATAWIDTH-1];
        sh_r <= sh_r << 1;
      end else begin
        DATA <= 1'b0;
      end
    end
  end

endmodule
